fp_mul_arbiter: RTL and testbench

//  Shares one combinational single-precision FP multiplier among NUM_REQ requesters.
//  - Grants one request per cycle, round-robin.
//  - Registers the operands into the shared multiplier and pipelines its result.
//  - Returns each product to the requester that issued it.
//  - Supports a flush/drain sequence so software can quiesce the unit.

---
 rtl/fp_mul_arbiter_if.sv | 28 ++
 rtl/fp_mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_arbiter_if.sv
// fp_mul_arbiter_if
//   Request/response bundle between NUM_REQ requesters and fp_mul_arbiter.
//   req_valid   per-requester request valid
//   req_ready   one-hot grant from the arbiter (handshake = valid & ready)
//   req_a/req_b per-requester operands, requester i in [i] (== [32*i+:32])
//   resp_valid  one-hot, 1-cycle pulse naming the requester of resp_result
//   resp_result product, meaningful only while resp_valid != 0
//   modport master: requester side; modport slave: arbiter side.
interface fp_mul_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0][31:0] req_a;
   logic [NUM_REQ-1:0][31:0] req_b;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [31:0]              resp_result;

   modport master (
      output req_valid, req_a, req_b,
      input  req_ready, resp_valid, resp_result
   );

   modport slave (
      input  req_valid, req_a, req_b,
      output req_ready, resp_valid, resp_result
   );
endinterface

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one external combinational FP32 multiplier among NUM_REQ requesters.
//   One round-robin grant per cycle; the granted operands are registered onto
//   mul_a/mul_b, the multiplier output is captured the next cycle and carried
//   through PIPE_STAGES registers together with a one-hot requester tag, so a
//   product returns PIPE_STAGES+1 cycles after its handshake, in issue order.
//   A flush request stops granting and waits for the pipeline to empty.
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   bus          fp_mul_arbiter_if.slave: req_valid/req_ready/req_a/req_b,
//                resp_valid/resp_result
//   mul_a, mul_b registered operands to the shared multiplier
//   mul_result   multiplier output (combinational from mul_a/mul_b)
//   flush        level request to drain in-flight work
//   flush_done   1-cycle pulse on returning to IDLE after a drain
//   busy         any operation in flight
// Configuration
//   FP_ARB_PRIO_EN  when defined, requester 0 has fixed top priority and the
//                   round-robin pointer rotates over 1..NUM_REQ-1 only.
module fp_mul_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int PIPE_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   fp_mul_arbiter_if.slave     bus,
   output logic [31:0]         mul_a,
   output logic [31:0]         mul_b,
   input  logic [31:0]         mul_result,
   input  logic                flush,
   output logic                flush_done,
   output logic                busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(PIPE_STAGES + 2);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                        state, state_nxt;
   logic [IDX_W-1:0]              ptr, ptr_nxt, gnt_idx, cand;
   logic [NUM_REQ-1:0]            gnt;
   logic                          found, grant_en, hs, retire, done_nxt;
   logic [CNT_W-1:0]              cnt, cnt_nxt;
   logic [PIPE_STAGES:0]          vld_pipe;
   logic [PIPE_STAGES:0][NUM_REQ-1:0] tag_pipe;
   logic [PIPE_STAGES:1][31:0]    res_pipe;

   // Grant selection. Gated by rst so req_ready reads 0 while in reset.
   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      cand     = '0;
      found    = 1'b0;
      grant_en = !rst && (state != DRAIN) && !flush;
      if (grant_en) begin
`ifdef FP_ARB_PRIO_EN
         if (bus.req_valid[0]) begin
            found = 1'b1;
         end else begin
            // ptr == 0 only right after reset; treat it as requester 1.
            for (int k = 0; k < NUM_REQ - 1; k++) begin
               cand = IDX_W'(1 + (((ptr == '0) ? 0 : int'(ptr) - 1) + k) % (NUM_REQ - 1));
               if (!found && bus.req_valid[cand]) begin
                  found   = 1'b1;
                  gnt_idx = cand;
               end
            end
         end
`else
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
               found   = 1'b1;
               gnt_idx = cand;
            end
         end
`endif
         if (found) gnt[gnt_idx] = 1'b1;
      end
      hs = found;
   end

   // Pointer advances past the winner; grants to requester 0 in priority
   // mode leave the rotation untouched.
   always_comb begin
      ptr_nxt = ptr;
`ifdef FP_ARB_PRIO_EN
      if (hs && gnt_idx != '0)
         ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1) : gnt_idx + IDX_W'(1);
`else
      if (hs)
         ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
   end

   assign retire = vld_pipe[PIPE_STAGES];

   always_comb begin
      cnt_nxt = cnt;
      case ({hs, retire})
         2'b10:   cnt_nxt = cnt + CNT_W'(1);
         2'b01:   cnt_nxt = cnt - CNT_W'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   // Control FSM. Grants never occur with flush high, so flush dominates.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (flush)   state_nxt = DRAIN;
            else if (hs) state_nxt = RUN;
         end
         RUN: begin
            if (flush)                        state_nxt = DRAIN;
            else if (!hs && cnt_nxt == '0)    state_nxt = IDLE;
         end
         DRAIN: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         flush_done <= 1'b0;
         vld_pipe   <= '0;
         tag_pipe   <= '0;
         res_pipe   <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         cnt        <= cnt_nxt;
         flush_done <= done_nxt;
         // Stage 0 tags the operand register; stages 1..PIPE_STAGES carry
         // the product captured from the multiplier.
         vld_pipe   <= {vld_pipe[PIPE_STAGES-1:0], hs};
         tag_pipe[0] <= gnt;
         for (int s = 1; s <= PIPE_STAGES; s++) tag_pipe[s] <= tag_pipe[s-1];
         res_pipe[1] <= mul_result;
         for (int s = 2; s <= PIPE_STAGES; s++) res_pipe[s] <= res_pipe[s-1];
         if (hs) begin
            mul_a <= bus.req_a[gnt_idx];
            mul_b <= bus.req_b[gnt_idx];
         end
      end
   end

   assign bus.req_ready   = gnt;
   assign bus.resp_valid  = tag_pipe[PIPE_STAGES];
   assign bus.resp_result = res_pipe[PIPE_STAGES];
   assign busy            = (cnt != '0);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter
//   Drives fp_mul_arbiter through its interface with a behavioural FP32
//   multiplier on mul_a/mul_b. A transaction-level model (pick-first-valid
//   round robin, queue of expected products with due cycle, drain flag)
//   predicts grants, responses, busy and flush_done every cycle. A vector
//   table covers grant ordering; hand sequences cover the multi-cycle cases.
module tb_fp_mul_arbiter;
   localparam int N  = 4;
   localparam int PS = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mul_a, mul_b, mul_result;
   logic        flush, flush_done, busy;

   always #5 clk = ~clk;

   fp_mul_arbiter_if #(.NUM_REQ(N)) bus();

   fp_mul_arbiter #(.NUM_REQ(N), .PIPE_STAGES(PS)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy)
   );

   // Normal-number FP32 multiply, truncating; zero exponent treated as zero.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [22:0] m;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin m = p[46:24]; e++; end
      else m = p[45:23];
      return {s, e[7:0], m};
   endfunction

   assign mul_result = fp_mul(mul_a, mul_b);

   typedef struct {int due; int id; logic [31:0] prod;} exp_t;
   typedef struct {logic [N-1:0] valid; logic [N-1:0] ready;} vec_t;

   exp_t q[$];
   vec_t vecs[10];
   int   cyc = 0, n_checks = 0, n_fail = 0, ptr = 0;
   bit   draining = 0, done_pend = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef FP_ARB_PRIO_EN
      int base;
      if (v[0]) return 0;
      base = (p == 0) ? 1 : p;
      for (int k = 0; k < N - 1; k++) begin
         if (v[1 + (base - 1 + k) % (N - 1)]) return 1 + (base - 1 + k) % (N - 1);
      end
      return -1;
`else
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
`endif
   endfunction

   function automatic int next_ptr(input int g, input int p);
`ifdef FP_ARB_PRIO_EN
      if (g == 0) return p;
      return (g == N - 1) ? 1 : g + 1;
`else
      return (g + 1) % N;
`endif
   endfunction

   // One clock cycle: entered at the falling edge with inputs applied.
   task automatic cycle();
      int           g, sz;
      logic [N-1:0] er, erv;
      bit           pop;
      #1;
      g = -1;
      if (!flush && !draining) g = pick(bus.req_valid, ptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      sz = q.size();
      chk("busy", 32'(busy), 32'(sz != 0));
      erv = '0;
      pop = 0;
      if (sz != 0 && q[0].due == cyc) begin
         erv[q[0].id] = 1'b1;
         pop = 1;
      end
      chk("resp_valid", 32'(bus.resp_valid), 32'(erv));
      if (pop) chk("resp_result", bus.resp_result, q[0].prod);
      chk("flush_done", 32'(flush_done), 32'(done_pend));
      done_pend = 0;
      if (draining) begin
         if (sz == 0) begin draining = 0; done_pend = 1; end
      end else if (flush) begin
         draining = 1;
      end
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back('{cyc + PS + 1, g, fp_mul(bus.req_a[g], bus.req_b[g])});
         ptr = next_ptr(g, ptr);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic model_clear();
      q.delete();
      ptr = 0;
      draining = 0;
      done_pend = 0;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.req_valid = '0;
      flush = 1'b0;
      repeat (n) begin @(posedge clk); cyc++; end
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   task automatic idle(input int n);
      bus.req_valid = '0;
      flush = 1'b0;
      repeat (n) cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int pulses;
      rst = 1'b1;
      flush = 1'b0;
      bus.req_valid = '1;
      for (int i = 0; i < N; i++) begin
         bus.req_a[i] = 32'h3F80_0000 + 32'(i << 20);
         bus.req_b[i] = 32'h4000_0000 + 32'(i << 19);
      end

`ifdef FP_ARB_PRIO_EN
      vecs[0] = '{4'b1001, 4'b0001}; vecs[1] = '{4'b1001, 4'b0001};
      vecs[2] = '{4'b1000, 4'b1000}; vecs[3] = '{4'b0110, 4'b0010};
      vecs[4] = '{4'b0110, 4'b0100}; vecs[5] = '{4'b1111, 4'b0001};
      vecs[6] = '{4'b1110, 4'b1000}; vecs[7] = '{4'b1110, 4'b0010};
      vecs[8] = '{4'b0000, 4'b0000}; vecs[9] = '{4'b0101, 4'b0001};
`else
      vecs[0] = '{4'b1111, 4'b0001}; vecs[1] = '{4'b1111, 4'b0010};
      vecs[2] = '{4'b0001, 4'b0001}; vecs[3] = '{4'b1001, 4'b1000};
      vecs[4] = '{4'b0000, 4'b0000}; vecs[5] = '{4'b0110, 4'b0010};
      vecs[6] = '{4'b0110, 4'b0100}; vecs[7] = '{4'b0101, 4'b0001};
      vecs[8] = '{4'b0100, 4'b0100}; vecs[9] = '{4'b0100, 4'b0100};
`endif

      // Reset held two cycles with every requester asserting.
      repeat (2) begin @(posedge clk); cyc++; end
      @(negedge clk);
      #1;
      chk("rst req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst mul_a", mul_a, 32'd0);
      chk("rst mul_b", mul_b, 32'd0);
      chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst resp_result", bus.resp_result, 32'd0);
      chk("rst flush_done", 32'(flush_done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_clear();

      // Grant ordering table, starting from the reset pointer.
      for (int i = 0; i < 10; i++) begin
         bus.req_valid = vecs[i].valid;
         #1;
         chk($sformatf("vec%0d ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
         cycle();
      end
      idle(5);

      // 2.0 * 3.0 from requester 1, response PS+1 cycles later.
      bus.req_a[1] = 32'h4000_0000;
      bus.req_b[1] = 32'h4040_0000;
      bus.req_valid = 4'b0010;
      cycle();
      bus.req_valid = '0;
      cycle();
      cycle();
      #1;
      chk("mul2x3 resp_valid", 32'(bus.resp_valid), 32'h2);
      chk("mul2x3 resp_result", bus.resp_result, 32'h40C0_0000);
      idle(3);

      // Requester 2 alone, back to back: 1.5 * 1.5 three times.
      bus.req_a[2] = 32'h3FC0_0000;
      bus.req_b[2] = 32'h3FC0_0000;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         bus.req_valid = (k < 3) ? 4'b0100 : 4'b0000;
         #1;
         if (bus.resp_valid == 4'b0100 && bus.resp_result == 32'h4010_0000) pulses++;
         cycle();
      end
      chk("lone req pulses", 32'(pulses), 32'd3);

      // All requesters valid for 8 cycles from a fresh pointer.
      do_reset(2);
      bus.req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         #1;
`ifdef FP_ARB_PRIO_EN
         chk("all valid grant", 32'(bus.req_ready), 32'h1);
`else
         chk("all valid grant", 32'(bus.req_ready), 32'(1 << (k % N)));
`endif
         if (k > 0) chk("all valid busy", 32'(busy), 32'd1);
         cycle();
      end
      idle(6);

      // Flush with two operations in flight.
      bus.req_valid = 4'b0011;
      cycle();
      cycle();
      bus.req_valid = '1;
      flush = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         #1;
         if (flush_done) pulses++;
         if (k > 0 && k < 4) chk("drain no grant", 32'(bus.req_ready), 32'd0);
         cycle();
         flush = 1'b0;
         if (k == 3) bus.req_valid = '0;
      end
      chk("flush_done pulses", 32'(pulses), 32'd1);
      chk("drain busy", 32'(busy), 32'd0);

      // Flush held in IDLE: drain, done, drain again.
      flush = 1'b1;
      repeat (6) cycle();
      idle(4);

      // Reset with two operations in flight discards both.
      bus.req_valid = '1;
      cycle();
      cycle();
      rst = 1'b1;
      bus.req_valid = '0;
      @(posedge clk); cyc++;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (bus.resp_valid != '0) pulses++;
         cycle();
      end
      chk("post-reset resp pulses", 32'(pulses), 32'd0);
      bus.req_valid = '1;
      #1;
      chk("post-reset first grant", 32'(bus.req_ready), 32'h1);
      cycle();
      idle(5);

`ifdef FP_ARB_PRIO_EN
      bus.req_valid = 4'b1001;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("prio req0 wins", 32'(bus.req_ready), 32'h1);
         cycle();
      end
      idle(5);
`endif

      // Randomized traffic with occasional flush.
      for (int k = 0; k < 400; k++) begin
         bus.req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            bus.req_a[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
            bus.req_b[i] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
         end
         flush = ($urandom_range(0, 19) == 0);
         cycle();
      end
      idle(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
